// File: rtl/fetch_pkg.sv
// Shared fetch types: queue entry layout, JAL opcode and J-immediate decode.
// Used by fetch_queue and instruction_fetch_unit.
package fetch_pkg;

  localparam int FETCH_XLEN = 32;

  localparam logic [6:0] OPCODE_JAL = 7'b1101111;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           instruction;
    logic                  predicted_taken;
    logic [FETCH_XLEN-1:0] predicted_next;
  } fetch_entry_t;

  function automatic logic [FETCH_XLEN-1:0] j_immediate(
    input logic [31:0] inst
  );
    logic [20:0] imm;
    imm = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    return {{(FETCH_XLEN-21){imm[20]}}, imm};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO of fetch entries with push, pop and flush.
// Head reads as all-zero while empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               wr_entry,
  output fetch_entry_t               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   head_ptr;
  logic [PW-1:0]   tail_ptr;
  logic [CW-1:0]   count;
  logic            do_pop;
  logic            do_push;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  assign do_pop  = pop & !empty & !flush;
  assign do_push = push & (!full | do_pop) & !flush;

  always_ff @(posedge clk) begin
    if (do_push) mem[tail_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_pop)  head_ptr <= head_ptr + PW'(1);
      if (do_push) tail_ptr <= tail_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head      = empty ? '0 : mem[head_ptr];
  assign occupancy = count;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Decoupled fetch front end: PC register, prediction and fetch queue.
// Define FETCH_JAL_PREDICT_EN to predict JAL targets at fetch.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int               XLEN            = FETCH_XLEN,
  parameter int               DEPTH           = 4,
  parameter logic [XLEN-1:0]  RESET_PC        = '0,
  parameter int               IMEM_ADDR_WIDTH = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_address,
  input  logic [31:0]                imem_data,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [31:0]                out_instruction,
  output logic [XLEN-1:0]            out_pc_plus_four,
  output logic                       out_predicted_taken,
  output logic [XLEN-1:0]            out_predicted_next,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pred_next;
  logic            pred_taken;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  fetch_entry_t    wr_entry;
  fetch_entry_t    head;

  assign imem_address = pc[IMEM_ADDR_WIDTH-1:0];

  always_comb begin
    pred_taken = 1'b0;
    pred_next  = pc + XLEN'(4);
`ifdef FETCH_JAL_PREDICT_EN
    if (imem_data[6:0] == OPCODE_JAL) begin
      pred_taken = 1'b1;
      pred_next  = pc + j_immediate(imem_data);
    end
`endif
  end

  // Redirect wins: no pop, no push, queue flushed this cycle.
  assign out_valid = !empty & !redirect;
  assign pop       = out_valid & out_ready;
  assign push      = !redirect & (!full | pop);

  always_comb begin
    wr_entry                 = '0;
    wr_entry.pc              = pc;
    wr_entry.instruction     = imem_data;
    wr_entry.predicted_taken = pred_taken;
    wr_entry.predicted_next  = pred_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= redirect_pc & ~XLEN'(3);
    end else if (push) begin
      pc <= pred_next;
    end
  end

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .flush    (redirect),
    .wr_entry (wr_entry),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .occupancy(occupancy)
  );

  assign out_pc              = head.pc;
  assign out_instruction     = head.instruction;
  assign out_pc_plus_four    = empty ? '0 : head.pc + XLEN'(4);
  assign out_predicted_taken = head.predicted_taken;
  assign out_predicted_next  = head.predicted_next;

endmodule
